acq_sequencer: RTL and testbench

Frame-level controller for the acquisition/readout path. Starts a frame on each period tick and steps through 1–4 virtual channels, each with a start pulse and a capture gate. It then drops `o_complite` to launch the 4-channel buffer readout and waits for the output stream to go quiet before it will accept the next frame. It sits between the register block (configuration, status) and the channel capture buffers plus the buffer reader that drains them.

---
 rtl/acq_sequencer.sv | 140 ++++++++++++++
 tb/tb_acq_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Frame sequencer for the acquisition path: period ticks start a frame of 1-4
// virtual-channel captures, then the readout stream is watched until it goes quiet.
module acq_sequencer #(
    parameter int QUIET = 4,
    parameter int PER_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [PER_W-1:0] i_period,
    input  logic [15:0]      i_window,
    input  logic [1:0]       i_nvch,
    input  logic             i_clr_ovr,
    input  logic             i_out_vld,
    input  logic             i_out_rdy,
    output logic [1:0]       o_acq_vchn,
    output logic             o_start,
    output logic             o_gate,
    output logic             o_complite,
    output logic             o_busy,
    output logic             o_overrun,
    output logic [15:0]      o_frame_cnt
);
    localparam int QW = $clog2(QUIET + 1);

    typedef enum logic [2:0] {IDLE, WAIT, START, ACQ, DRAIN} state_t;

    state_t           state;
    logic [PER_W-1:0] per_cnt, per_lat, per_eff;
    logic             en_d, en_rise, tick;
    logic [15:0]      wcnt, win_eff, cap_rem;
    logic [1:0]       nv_lat, nv_cur;
    logic [QW-1:0]    qcnt;
    logic             win_done, more_vch, q_inc, q_done;

    // On the enable-rise cycle the period register is not loaded yet, so use the port.
    assign en_rise = i_enable & ~en_d;
    assign per_eff = en_rise ? i_period : per_lat;
    assign tick    = i_enable && (per_eff != '0) && (per_cnt == per_eff - PER_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            per_lat <= '0;
            en_d    <= 1'b0;
        end else begin
            en_d <= i_enable;
            if (!i_enable) begin
                per_cnt <= '0;
            end else if (per_eff == '0 || tick) begin
                // A zero period keeps re-sampling so a new nonzero value takes effect.
                per_cnt <= '0;
                per_lat <= i_period;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
                if (en_rise) per_lat <= i_period;
            end
        end
    end

    // START samples window/nvch straight from the ports; ACQ uses the loaded values.
    assign win_eff  = (i_window == 16'd0) ? 16'd1 : i_window;
    assign cap_rem  = (state == START) ? win_eff : wcnt;
    assign nv_cur   = (state == START) ? i_nvch : nv_lat;
    assign win_done = (cap_rem == 16'd1);
    assign more_vch = (o_acq_vchn < nv_cur);
    assign q_inc    = ~i_out_vld & i_out_rdy;
    assign q_done   = q_inc && (qcnt == QW'(QUIET - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wcnt        <= '0;
            nv_lat      <= '0;
            qcnt        <= '0;
            o_acq_vchn  <= '0;
            o_start     <= 1'b0;
            o_gate      <= 1'b0;
            o_complite  <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_start <= 1'b0;

            if (tick && state != WAIT) o_overrun <= 1'b1;
            else if (i_clr_ovr)        o_overrun <= 1'b0;

            case (state)
                IDLE: if (i_enable) state <= WAIT;

                WAIT: begin
                    if (!i_enable) begin
                        state <= IDLE;
                    end else if (tick || per_eff == '0) begin
                        state      <= START;
                        o_acq_vchn <= '0;
                        o_start    <= 1'b1;
                        o_gate     <= 1'b1;
                        o_complite <= 1'b1;
                        o_busy     <= 1'b1;
                    end
                end

                START, ACQ: begin
                    if (state == START) nv_lat <= i_nvch;
                    if (!win_done) begin
                        wcnt  <= cap_rem - 16'd1;
                        state <= ACQ;
                    end else if (more_vch) begin
                        o_acq_vchn <= o_acq_vchn + 2'd1;
                        o_start    <= 1'b1;
                        state      <= START;
                    end else begin
                        o_gate     <= 1'b0;
                        o_complite <= 1'b0;
                        qcnt       <= '0;
                        state      <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (i_out_vld) begin
                        qcnt <= '0;
                    end else if (q_done) begin
                        qcnt        <= '0;
                        o_busy      <= 1'b0;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        state       <= i_enable ? WAIT : IDLE;
                    end else if (i_out_rdy) begin
                        qcnt <= qcnt + QW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: frame-schedule model compared every cycle, plus
// directed scenarios with hand-computed cycle numbers.
module tb_acq_sequencer;
    localparam int QUIET = 4;
    localparam int PER_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             i_enable = 1'b0;
    logic [PER_W-1:0] i_period = '0;
    logic [15:0]      i_window = '0;
    logic [1:0]       i_nvch = '0;
    logic             i_clr_ovr = 1'b0;
    logic             i_out_vld = 1'b0;
    logic             i_out_rdy = 1'b1;
    logic [1:0]       o_acq_vchn;
    logic             o_start, o_gate, o_complite, o_busy, o_overrun;
    logic [15:0]      o_frame_cnt;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    acq_sequencer #(.QUIET(QUIET), .PER_W(PER_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_period(i_period),
        .i_window(i_window), .i_nvch(i_nvch), .i_clr_ovr(i_clr_ovr),
        .i_out_vld(i_out_vld), .i_out_rdy(i_out_rdy), .o_acq_vchn(o_acq_vchn),
        .o_start(o_start), .o_gate(o_gate), .o_complite(o_complite),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    // Model: a frame is a capture of w*(n+1) cycles followed by a quiet-count drain.
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DRAIN = 3;
    int          m_mode, m_k, m_pos, m_w, m_n, m_q;
    logic [1:0]  m_vchn;
    logic        m_ov;
    logic [15:0] m_frames;
    logic [22:0] exp_vec;

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_pos = 0; m_w = 1; m_n = 0; m_q = 0;
        m_vchn = '0; m_ov = 1'b0; m_frames = '0;
        exp_vec = '0;
    endtask

    task automatic model_step();
        int  p;
        bit  tk, cap;
        p  = int'(i_period);
        tk = i_enable && (p != 0) && ((m_k % p) == p - 1);
        m_k = i_enable ? m_k + 1 : 0;
        if (tk && m_mode != M_WAIT) m_ov = 1'b1;
        else if (i_clr_ovr)         m_ov = 1'b0;
        case (m_mode)
            M_IDLE: if (i_enable) m_mode = M_WAIT;
            M_WAIT: begin
                if (!i_enable) m_mode = M_IDLE;
                else if (p == 0 || tk) begin
                    m_mode = M_CAP; m_pos = 0;
                    m_w = (i_window == 0) ? 1 : int'(i_window);
                    m_n = int'(i_nvch);
                end
            end
            M_CAP: begin
                m_pos++;
                if (m_pos == m_w * (m_n + 1)) begin m_mode = M_DRAIN; m_q = 0; end
            end
            default: begin
                if (i_out_vld) m_q = 0;
                else if (i_out_rdy) m_q++;
                if (m_q == QUIET) begin
                    m_frames = m_frames + 16'd1;
                    m_mode = i_enable ? M_WAIT : M_IDLE;
                end
            end
        endcase
        cap = (m_mode == M_CAP);
        if (cap) m_vchn = 2'(m_pos / m_w);
        exp_vec = {m_vchn, cap && (m_pos % m_w == 0), cap, cap,
                   (m_mode == M_CAP || m_mode == M_DRAIN), m_ov, m_frames};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [22:0] act;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                act = {o_acq_vchn, o_start, o_gate, o_complite, o_busy, o_overrun, o_frame_cnt};
                checks++;
                if (act !== exp_vec) begin
                    failures++;
                    $display("FAIL cycle_model t=%0t got %h want %h", $time, act, exp_vec);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic nxt(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        i_enable = 1'b0; i_clr_ovr = 1'b0; i_out_vld = 1'b0; i_out_rdy = 1'b1;
        rst_n = 1'b0;
        nxt(2);
        rst_n = 1'b1;
        nxt(1);
    endtask

    // Returns the number of cycles until o_start is seen (caller is in cycle 0).
    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!o_start && cyc < 1000) begin nxt(1); cyc++; end
    endtask

    function automatic logic [22:0] outs();
        return {o_acq_vchn, o_start, o_gate, o_complite, o_busy, o_overrun, o_frame_cnt};
    endfunction

    initial begin
        int cyc, n, g, s;
        logic [31:0] smask;
        logic [7:0]  vpat;

        #1 rst_n = 1'b0;
        nxt(3);
        chk("reset_outputs", 32'(outs()), 0);
        rst_n = 1'b1;
        nxt(1);
        cmp_en = 1'b1;
        chk("idle_after_reset", 32'(outs()), 0);

        // Single-vchn frame
        i_period = 100; i_window = 10; i_nvch = 0; i_enable = 1'b1;
        wait_start(cyc);
        chk("t1_start_cycle", cyc, 100);
        g = 0;
        while (o_gate && g < 50) begin g++; nxt(1); end
        chk("t1_gate_len", g, 10);
        chk("t1_complite_low_busy", {o_complite, o_busy}, 2'b01);
        n = 0;
        while (o_frame_cnt != 16'd1 && n < 20) begin n++; nxt(1); end
        chk("t1_drain_len", n, 4);

        // Four vchn
        do_reset();
        i_period = 100; i_window = 5; i_nvch = 3; i_enable = 1'b1;
        wait_start(cyc);
        chk("t2_start_cycle", cyc, 100);
        smask = '0; vpat = '0; g = 0; s = 0;
        for (int j = 0; j < 20; j++) begin
            smask[j] = o_start;
            if (o_gate) g++;
            if (o_start && s < 4) begin vpat[2*s +: 2] = o_acq_vchn; s++; end
            nxt(1);
        end
        chk("t2_start_mask", smask, 32'h8421);
        chk("t2_vchn_seq", vpat, 8'he4);
        chk("t2_gate_len", g, 20);
        chk("t2_after_gate", {o_gate, o_complite, o_busy}, 3'b001);

        // Drain hold
        do_reset();
        i_period = 500; i_window = 5; i_nvch = 0; i_enable = 1'b1;
        wait_start(cyc);
        n = 0;
        while (o_complite && n < 100) begin n++; nxt(1); end
        chk("t3_capture_len", n, 5);
        for (int i = 0; i < 50; i++) begin
            nxt(1);
            i_out_vld = (i % 2 == 1); i_out_rdy = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            nxt(1);
            if (j == 0) chk("t3_held_after_vld", {o_busy, o_frame_cnt}, {1'b1, 16'd0});
            if (j == 6) chk("t3_before_exit", {o_busy, o_frame_cnt}, {1'b1, 16'd0});
            if (j == 7) chk("t3_exit", {o_busy, o_frame_cnt}, {1'b0, 16'd1});
            i_out_vld = 1'b0; i_out_rdy = (j % 2 == 0);
        end
        i_out_rdy = 1'b1;

        // Overrun
        do_reset();
        i_period = 20; i_window = 30; i_nvch = 0; i_enable = 1'b1;
        nxt(39);
        chk("t4_ovr_before", o_overrun, 0);
        nxt(1);
        chk("t4_ovr_set", o_overrun, 1);
        chk("t4_no_restart", {o_start, o_gate}, 2'b01);
        nxt(5);
        i_clr_ovr = 1'b1;
        nxt(1);
        i_clr_ovr = 1'b0;
        chk("t4_ovr_cleared", o_overrun, 0);
        nxt(14);
        chk("t4_second_frame", {o_start, o_frame_cnt}, {1'b1, 16'd1});
        nxt(19);
        chk("t4_pre_tick", {o_overrun, o_gate}, 2'b01);
        i_clr_ovr = 1'b1;
        nxt(1);
        i_clr_ovr = 1'b0;
        chk("t4_set_wins", o_overrun, 1);

        // Free-run, zero window
        do_reset();
        i_period = 0; i_window = 0; i_nvch = 0; i_enable = 1'b1;
        nxt(2);
        chk("t5_first_start", {o_start, o_gate, o_complite}, 3'b111);
        nxt(1);
        chk("t5_gate_one", {o_gate, o_busy}, 2'b01);
        nxt(4);
        chk("t5_wait", {o_busy, o_frame_cnt}, {1'b0, 16'd1});
        nxt(1);
        chk("t5_second_start", o_start, 1);
        nxt(6);
        chk("t5_third_start", {o_start, o_frame_cnt}, {1'b1, 16'd2});

        // Disable mid-ACQ, then async reset mid-ACQ
        do_reset();
        i_period = 30; i_window = 10; i_nvch = 1; i_enable = 1'b1;
        nxt(35);
        i_enable = 1'b0;
        nxt(14);
        chk("t6_gate_end", {o_gate, o_acq_vchn}, 3'b101);
        nxt(1);
        chk("t6_drain", {o_complite, o_busy}, 2'b01);
        nxt(4);
        chk("t6_idle", {o_busy, o_frame_cnt}, {1'b0, 16'd1});
        nxt(40);
        chk("t6_stays_idle", {o_busy, o_gate, o_frame_cnt}, {2'b00, 16'd1});
        i_enable = 1'b1;
        nxt(40);
        chk("t6_in_acq", o_gate, 1);
        #1 rst_n = 1'b0;
        #1 chk("t6_async_reset", 32'(outs()), 0);
        nxt(2);
        rst_n = 1'b1;
        nxt(29);
        chk("t6_restart_pre", o_start, 0);
        nxt(1);
        chk("t6_restart", o_start, 1);
        nxt(3);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
